// File: rtl/forwarding_hazard_ctrl.sv
// EX-stage operand-forwarding select generation and load-use stall control
// for the pipelined MIPS core, built on a shadow pipeline of EX/MEM/WB fields.
module forwarding_hazard_ctrl #(
    parameter int REG_ADDR_BITS     = 5,
    parameter int LOAD_STALL_CYCLES = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     hold_i,
    input  logic                     flush_i,
    input  logic [REG_ADDR_BITS-1:0] id_rs_i,
    input  logic [REG_ADDR_BITS-1:0] id_rt_i,
    input  logic [REG_ADDR_BITS-1:0] id_dest_i,
    input  logic                     id_regwrite_i,
    input  logic                     id_memread_i,
    output logic                     stall_o,
    output logic                     bubble_o,
    output logic [1:0]               fwd_a_sel_o,
    output logic [1:0]               fwd_b_sel_o
);

    typedef enum logic [0:0] {ST_RUN = 1'b0, ST_STALL = 1'b1} state_e;

    localparam logic [REG_ADDR_BITS-1:0] REG_ZERO = {REG_ADDR_BITS{1'b0}};
    localparam int CNT_INIT_I = (LOAD_STALL_CYCLES > 1) ? (LOAD_STALL_CYCLES - 2) : 0;
    localparam logic [1:0] CNT_INIT = 2'(CNT_INIT_I);

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_WB  = 2'b01;
    localparam logic [1:0] SEL_MEM = 2'b10;

    logic [REG_ADDR_BITS-1:0] ex_rs_q, ex_rs_d, ex_rt_q, ex_rt_d, ex_dest_q, ex_dest_d;
    logic                     ex_regwrite_q, ex_regwrite_d, ex_memread_q, ex_memread_d;
    logic [REG_ADDR_BITS-1:0] mem_dest_q, mem_dest_d, wb_dest_q, wb_dest_d;
    logic                     mem_regwrite_q, mem_regwrite_d, wb_regwrite_q, wb_regwrite_d;
    state_e                   state_q, state_d;
    logic [1:0]               cnt_q, cnt_d;
    logic                     hz_s, stall_s, bubble_s;

    // MEM result has priority over WB because it is the younger producer; $0 never forwards.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_ADDR_BITS-1:0] src,
        input logic                     mem_rw,
        input logic [REG_ADDR_BITS-1:0] mem_dest,
        input logic                     wb_rw,
        input logic [REG_ADDR_BITS-1:0] wb_dest
    );
        logic [1:0] sel;
        sel = SEL_RF;
        if (mem_rw && (mem_dest != REG_ZERO) && (mem_dest == src)) begin
            sel = SEL_MEM;
        end else if (wb_rw && (wb_dest != REG_ZERO) && (wb_dest == src)) begin
            sel = SEL_WB;
        end else begin
            sel = SEL_RF;
        end
        return sel;
    endfunction

    // Operand selects and stall/bubble decode.
    always_comb begin
        fwd_a_sel_o = fwd_sel(ex_rs_q, mem_regwrite_q, mem_dest_q, wb_regwrite_q, wb_dest_q);
        fwd_b_sel_o = fwd_sel(ex_rt_q, mem_regwrite_q, mem_dest_q, wb_regwrite_q, wb_dest_q);
        hz_s = ex_memread_q && (ex_dest_q != REG_ZERO) &&
               ((ex_dest_q == id_rs_i) || (ex_dest_q == id_rt_i));
        stall_s  = 1'b0;
        bubble_s = 1'b0;
        case (state_q)
            ST_RUN: begin
                stall_s  = hz_s && !flush_i;
                bubble_s = stall_s || flush_i;
            end
            ST_STALL: begin
                stall_s  = !flush_i;
                bubble_s = 1'b1;
            end
            default: begin
                stall_s  = 1'b0;
                bubble_s = 1'b1;
            end
        endcase
        stall_o  = stall_s;
        bubble_o = bubble_s;
    end

    // Shadow pipeline advance and stall FSM next state; hold_i freezes everything.
    always_comb begin
        ex_rs_d        = ex_rs_q;
        ex_rt_d        = ex_rt_q;
        ex_dest_d      = ex_dest_q;
        ex_regwrite_d  = ex_regwrite_q;
        ex_memread_d   = ex_memread_q;
        mem_dest_d     = mem_dest_q;
        mem_regwrite_d = mem_regwrite_q;
        wb_dest_d      = wb_dest_q;
        wb_regwrite_d  = wb_regwrite_q;
        state_d        = state_q;
        cnt_d          = cnt_q;
        if (!hold_i) begin
            wb_dest_d      = mem_dest_q;
            wb_regwrite_d  = mem_regwrite_q;
            mem_dest_d     = ex_dest_q;
            mem_regwrite_d = ex_regwrite_q;
            if (bubble_s) begin
                ex_rs_d       = REG_ZERO;
                ex_rt_d       = REG_ZERO;
                ex_dest_d     = REG_ZERO;
                ex_regwrite_d = 1'b0;
                ex_memread_d  = 1'b0;
            end else begin
                ex_rs_d       = id_rs_i;
                ex_rt_d       = id_rt_i;
                ex_dest_d     = id_dest_i;
                ex_regwrite_d = id_regwrite_i;
                ex_memread_d  = id_memread_i;
            end
            case (state_q)
                ST_RUN: begin
                    if (stall_s && (LOAD_STALL_CYCLES > 1)) begin
                        state_d = ST_STALL;
                        cnt_d   = CNT_INIT;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_STALL: begin
                    if (flush_i || (cnt_q == 2'd0)) begin
                        state_d = ST_RUN;
                    end else begin
                        cnt_d = cnt_q - 2'd1;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                    cnt_d   = 2'd0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_rs_q        <= REG_ZERO;
            ex_rt_q        <= REG_ZERO;
            ex_dest_q      <= REG_ZERO;
            ex_regwrite_q  <= 1'b0;
            ex_memread_q   <= 1'b0;
            mem_dest_q     <= REG_ZERO;
            mem_regwrite_q <= 1'b0;
            wb_dest_q      <= REG_ZERO;
            wb_regwrite_q  <= 1'b0;
            state_q        <= ST_RUN;
            cnt_q          <= 2'd0;
        end else begin
            ex_rs_q        <= ex_rs_d;
            ex_rt_q        <= ex_rt_d;
            ex_dest_q      <= ex_dest_d;
            ex_regwrite_q  <= ex_regwrite_d;
            ex_memread_q   <= ex_memread_d;
            mem_dest_q     <= mem_dest_d;
            mem_regwrite_q <= mem_regwrite_d;
            wb_dest_q      <= wb_dest_d;
            wb_regwrite_q  <= wb_regwrite_d;
            state_q        <= state_d;
            cnt_q          <= cnt_d;
        end
    end

endmodule

// File: doc/forwarding_hazard_ctrl.md
Name: forwarding_hazard_ctrl

Overview:
- Sequences the two EX-stage ALU-operand 3-to-1 multiplexers of the pipelined MIPS core.
- Keeps a shadow pipeline of register-address and control bits for the EX, MEM and WB stages.
- Drives the 2-bit operand selects and detects load-use hazards.
- Runs a stall FSM that freezes PC and IF/ID and injects ID/EX bubbles.

Parameters:
- REG_ADDR_BITS, 5, width of register specifiers.
- LOAD_STALL_CYCLES, 1, stall cycles per load-use hazard; legal range 1..3.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high.
- hold_i  input  1  global pipeline freeze (memory wait); freezes all internal state.
- flush_i  input  1  branch/jump taken; the instruction in ID is squashed.
- id_rs_i  input  REG_ADDR_BITS  rs of the instruction in ID.
- id_rt_i  input  REG_ADDR_BITS  rt of the instruction in ID.
- id_dest_i  input  REG_ADDR_BITS  destination register of the instruction in ID (after RegDst).
- id_regwrite_i  input  1  the instruction in ID writes the register file.
- id_memread_i  input  1  the instruction in ID is a load.
- stall_o  output  1  hold PC and IF/ID.
- bubble_o  output  1  load zeros into the ID/EX control bits this cycle.
- fwd_a_sel_o  output  2  select for operand-A mux.
- fwd_b_sel_o  output  2  select for operand-B mux.

Behaviour:
- Mux encoding: 00 = ID/EX register-file value; 01 = MEM/WB write-back data; 10 = EX/MEM ALU result; 11 is never driven.
- Shadow registers:
  - EX slot: rs, rt, dest, regwrite, memread.
  - MEM slot: dest, regwrite.
  - WB slot: dest, regwrite.
- Each rising edge with hold_i=0:
  - WB <= MEM and MEM <= EX.
  - If bubble_o=1, EX <= bubble (all fields 0); otherwise EX <= id_* inputs.
- hold_i=1: every shadow register and the FSM keep their value. Outputs still evaluate from the held state.
- fwd_a_sel_o, evaluated combinationally from shadow state only, in priority order:
  - 10 if MEM.regwrite and MEM.dest!=0 and MEM.dest==EX.rs;
  - else 01 if WB.regwrite and WB.dest!=0 and WB.dest==EX.rs;
  - else 00.
  - fwd_b_sel_o follows the same rules using EX.rt.
  - Register 0 never forwards.
- Hazard term: hz = EX.memread and EX.dest!=0 and (EX.dest==id_rs_i or EX.dest==id_rt_i).
- FSM state RUN:
  - stall_o = hz and !flush_i; bubble_o = stall_o or flush_i.
  - On an edge with stall_o=1 and hold_i=0: if LOAD_STALL_CYCLES>1, go to STALL with cnt <= LOAD_STALL_CYCLES-2; otherwise stay in RUN.
- FSM state STALL:
  - stall_o = !flush_i; bubble_o = 1.
  - On an edge with hold_i=0: if flush_i or cnt==0, go to RUN; otherwise cnt <= cnt-1.
- Latency: a single load-use hazard with LOAD_STALL_CYCLES=1 gives exactly one stall/bubble cycle. The dependent instruction then reaches EX with the load in WB, so its select is 01.
- The register file is write-first. No WB-to-ID forwarding is produced here.
- flush_i and a hazard in the same cycle: the flush wins, so stall_o=0, bubble_o=1 and the FSM goes to RUN.
- Reset, including mid-stall: state RUN, cnt=0, all shadow fields 0. Consequently stall_o=0, bubble_o=0 (absent flush_i), and both selects = 00 in the cycle after reset.
- No outputs are registered. All outputs are free of combinational loops with respect to the id_* inputs, except stall_o/bubble_o, which depend on id_rs_i, id_rt_i and flush_i.

Test Plan:
- Back-to-back ALU ops `add $3,$1,$2` then `sub $5,$3,$4` -> fwd_a_sel_o=10 when the sub is in EX; then `or $6,$3,$0` one instruction later -> fwd_a_sel_o=01, fwd_b_sel_o=00.
- `lw $4,0($1)` then `add $6,$4,$4` -> stall_o=1 and bubble_o=1 for one cycle; the add reaches EX with fwd_a_sel_o=fwd_b_sel_o=01.
- Same sequence with LOAD_STALL_CYCLES=3 -> stall_o high for exactly 3 cycles; the add reaches EX with selects 00.
- Destination $0 written by the previous two instructions and read by the next -> selects stay 00 and stall_o never asserts.
- Load-use hazard with flush_i=1 in the same cycle -> stall_o=0, bubble_o=1, FSM in RUN on the next cycle. hold_i=1 for 4 cycles mid-STALL -> cnt and selects frozen, and the stall resumes with its remaining count.
- reset asserted during a STALL -> on the next edge stall_o=0, bubble_o=0, selects 00. Stale MEM/WB destinations must not forward afterward.
